// File: rtl/mac8_acc_sequencer.sv
// mac8_acc_sequencer: takes 8x8 unsigned operand pairs, registers the product and
// drives it with the accumulator onto an external 16-bit adder, then captures the
// adder's sum as the new running MAC result. Keeps a sticky wrap-around flag.
module mac8_acc_sequencer #(
  parameter int OP_W  = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a_in,
  input  logic [OP_W-1:0]  b_in,
  input  logic             clr,
  output logic [ACC_W-1:0] add_a,
  output logic [ACC_W-1:0] add_b,
  output logic             add_cin,
  input  logic [ACC_W-1:0] add_sum,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] add_a_q, add_a_d;   // doubles as the registered product
  logic [ACC_W-1:0] add_b_q, add_b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic             clr_pend_q, clr_pend_d;
  logic             accept_s;

  // An unsigned sum that ends up below one of its addends has wrapped.
  function automatic logic sum_wrapped(input logic [ACC_W-1:0] sum, input logic [ACC_W-1:0] addend);
    return (sum < addend);
  endfunction

  assign accept_s = (state_q == S_IDLE) && in_valid;

  // Next-state, adder operand load, accumulator capture, overflow and clear tracking.
  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    ovf_d       = clr ? 1'b0 : ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Operands are loaded at the accept edge so they are stable for the
          // whole MUL and ACC cycles while the external adder settles.
          add_a_d = ACC_W'(a_in) * ACC_W'(b_in);
          add_b_d = (clr_pend_q || clr) ? {ACC_W{1'b0}} : acc_q;
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_d       = add_sum;
        out_valid_d = 1'b1;
        // A wrap on this accumulate takes priority over a clr seen on the same edge.
        if (sum_wrapped(add_sum, add_a_q)) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = clr ? 1'b0 : ovf_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pending clear is consumed by the accept that loads B; a clr arriving
    // while busy stays pending for the next accepted pair.
    if (accept_s) begin
      clr_pend_d = 1'b0;
    end else if (clr) begin
      clr_pend_d = 1'b1;
    end else begin
      clr_pend_d = clr_pend_q;
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      add_a_q     <= {ACC_W{1'b0}};
      add_b_q     <= {ACC_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = 1'b0;
  assign acc_out   = acc_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac8_acc_sequencer.sv
// Directed bench for mac8_acc_sequencer with an external adder model, a
// transaction-level reference model checked every cycle, and literal spot checks.
module tb_mac8_acc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        clr;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic [15:0] acc_out;
  logic        out_valid;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  mac8_acc_sequencer #(.OP_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .clr(clr), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .acc_out(acc_out),
    .out_valid(out_valid), .ovf(ovf)
  );

  // External 16-bit adder, combinational.
  assign add_sum = add_a + add_b + {15'd0, add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_busy;    // cycles left until the pair in flight is captured
  logic [15:0] m_a, m_b, m_acc;
  logic        m_valid, m_ovf, m_pend;

  function automatic logic [16:0] wide_sum(input logic [15:0] x, input logic [15:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_a <= 16'd0; m_b <= 16'd0; m_acc <= 16'd0;
      m_valid <= 1'b0; m_ovf <= 1'b0; m_pend <= 1'b0;
    end else begin
      if (m_busy == 0 && in_valid) begin
        m_a    <= {8'd0, a_in} * {8'd0, b_in};
        m_b    <= (m_pend || clr) ? 16'd0 : m_acc;
        m_busy <= 2;
        m_pend <= 1'b0;
      end else begin
        if (clr) m_pend <= 1'b1;
        if (m_busy != 0) m_busy <= m_busy - 1;
      end
      m_valid <= (m_busy == 1);
      if (m_busy == 1) m_acc <= m_a + m_b;
      if (m_busy == 1 && wide_sum(m_a, m_b) > 17'h0FFFF) m_ovf <= 1'b1;
      else if (clr) m_ovf <= 1'b0;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  {31'd0, in_ready},  {31'd0, (m_busy == 0)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("acc_out",   {16'd0, acc_out},   {16'd0, m_acc});
      chk("ovf",       {31'd0, ovf},       {31'd0, m_ovf});
      chk("add_a",     {16'd0, add_a},     {16'd0, m_a});
      chk("add_b",     {16'd0, add_b},     {16'd0, m_b});
      chk("add_cin",   {31'd0, add_cin},   32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present a pair; returns after the accept edge (+2 time units, i.e. in MUL).
  task automatic do_accept(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic keep, output int waits);
    a_in = a; b_in = b; clr = c; in_valid = 1'b1; waits = 0;
    while (!in_ready && waits < 10) begin
      @(posedge clk); #2;
      waits++;
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    clr = 1'b0;
    if (!keep) in_valid = 1'b0;
  endtask

  // Wait (bounded) until out_valid is seen high, sampled 2 units after an edge.
  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk); #2;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  int          w;
  logic [15:0] sum_ref;
  logic [7:0]  ra, rb;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a_in = 8'd0; b_in = 8'd0; clr = 1'b0;
    #12;
    chk("rst_acc",   {16'd0, acc_out}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_add_a", {16'd0, add_a}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // Single MAC 3*5 from reset
    do_accept(8'd3, 8'd5, 1'b0, 1'b0, w);
    chk("t2_add_a", {16'd0, add_a}, 32'h000F);
    chk("t2_add_b", {16'd0, add_b}, 32'h0000);
    wait_out();
    chk("t2_acc", {16'd0, acc_out}, 32'h000F);
    @(posedge clk); #2;
    chk("t2_single_pulse", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of MUL: no update survives
    do_accept(8'd7, 8'd7, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    #1;
    chk("t1_acc_in_rst", {16'd0, acc_out}, 32'd0);
    chk("t1_add_a_in_rst", {16'd0, add_a}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      chk("t1_no_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("t1_acc", {16'd0, acc_out}, 32'd0);
    chk("t1_ovf", {31'd0, ovf}, 32'd0);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);

    // Accumulate, with a second pair held while busy
    do_accept(8'd3, 8'd5, 1'b0, 1'b0, w);
    wait_out();
    do_accept(8'h10, 8'h10, 1'b0, 1'b0, w);
    chk("t3_add_b", {16'd0, add_b}, 32'h000F);
    do_accept(8'h01, 8'h01, 1'b0, 1'b0, w);
    chk("t3_held_waits", w, 32'd2);
    chk("t3_acc_mid", {16'd0, acc_out}, 32'h010F);
    wait_out();
    chk("t3_acc", {16'd0, acc_out}, 32'h0110);

    // Wrap: build 0xFFF0, then add 0x20
    do_accept(8'hFF, 8'hFF, 1'b1, 1'b0, w);
    wait_out();
    do_accept(8'h05, 8'h63, 1'b0, 1'b0, w);
    wait_out();
    chk("t4_acc_pre", {16'd0, acc_out}, 32'hFFF0);
    do_accept(8'h20, 8'h01, 1'b0, 1'b0, w);
    wait_out();
    chk("t4_acc_wrap", {16'd0, acc_out}, 32'h0010);
    chk("t4_ovf_set", {31'd0, ovf}, 32'd1);
    do_accept(8'h01, 8'h01, 1'b0, 1'b0, w);
    wait_out();
    chk("t4_acc_next", {16'd0, acc_out}, 32'h0011);
    chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Clear together with accept
    do_accept(8'h14, 8'hE9, 1'b1, 1'b0, w);
    chk("t5_ovf_clr", {31'd0, ovf}, 32'd0);
    wait_out();
    chk("t5_acc_pre", {16'd0, acc_out}, 32'h1234);
    do_accept(8'h02, 8'h02, 1'b1, 1'b0, w);
    chk("t5_add_b", {16'd0, add_b}, 32'h0000);
    wait_out();
    chk("t5_acc", {16'd0, acc_out}, 32'h0004);
    chk("t5_ovf", {31'd0, ovf}, 32'd0);

    // clr pulsed while busy: the next pair starts from zero, acc_out untouched
    do_accept(8'h01, 8'h01, 1'b0, 1'b0, w);
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    wait_out();
    chk("tc_acc_kept", {16'd0, acc_out}, 32'h0005);
    do_accept(8'h03, 8'h03, 1'b0, 1'b0, w);
    chk("tc_add_b", {16'd0, add_b}, 32'h0000);
    wait_out();
    chk("tc_acc", {16'd0, acc_out}, 32'h0009);

    // Back-to-back stream, in_valid held high throughout
    sum_ref = 16'd0;
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      sum_ref = sum_ref + {8'd0, ra} * {8'd0, rb};
      do_accept(ra, rb, (i == 0), 1'b1, w);
      if (i > 0) chk("t6_spacing", w + 1, 32'd3);
    end
    in_valid = 1'b0;
    wait_out();
    chk("t6_acc", {16'd0, acc_out}, {16'd0, sum_ref});

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
